// File: rtl/axi_pkg.sv
// Shared types for the AXI4-Lite 1-to-2 address decoder: target selects,
// response codes and the read/write FSM state encodings.
package axi_pkg;

  typedef enum logic [1:0] {
    TGT_S0,
    TGT_S1,
    TGT_ERR
  } tgt_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_if.sv
// AXI4-Lite bundle with 32-bit address/data and a 4-bit write mask.
interface axi_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_addr_decode.sv
// Combinational address-to-target decode; slave 0 wins when both regions hit.
module axi_addr_decode
  import axi_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_MASK = 32'hF800_0000,
  parameter logic [31:0] S1_BASE = 32'hA000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
  input  logic [31:0] addr_i,
  output tgt_t        tgt_o
);

  always_comb begin
    if ((addr_i & S0_MASK) == S0_BASE)      tgt_o = TGT_S0;
    else if ((addr_i & S1_MASK) == S1_BASE) tgt_o = TGT_S1;
    else                                    tgt_o = TGT_ERR;
  end

endmodule

// File: rtl/axi_decoder.sv
// AXI4-Lite 1-to-2 decoder: independent read and write FSMs route one upstream
// master to s0/s1 by address, answering unmapped accesses locally with DECERR.
module axi_decoder
  import axi_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_MASK = 32'hF800_0000,
  parameter logic [31:0] S1_BASE = 32'hA000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
  input  logic  clk,
  input  logic  reset,
  axi_if.slave  m,
  axi_if.master s0,
  axi_if.master s1
);

  tgt_t      ar_tgt, aw_tgt, rd_tgt_q, wr_tgt_q;
  rd_state_t rd_state_q;
  wr_state_t wr_state_q;
  logic      rd_idle, rd_resp, wr_idle, wr_data, wr_resp;
  logic      ar_hs, r_hs, aw_hs, w_hs, b_hs;

  axi_addr_decode #(.S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK))
    u_ar_decode (.addr_i(m.araddr), .tgt_o(ar_tgt));

  axi_addr_decode #(.S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK))
    u_aw_decode (.addr_i(m.awaddr), .tgt_o(aw_tgt));

  // Phase qualifiers are gated by reset so every valid/ready drops while it is high.
  assign rd_idle = !reset && (rd_state_q == R_IDLE);
  assign rd_resp = !reset && (rd_state_q == R_RESP);
  assign wr_idle = !reset && (wr_state_q == W_IDLE);
  assign wr_data = !reset && (wr_state_q == W_DATA);
  assign wr_resp = !reset && (wr_state_q == W_RESP);

  assign ar_hs = m.arvalid && m.arready;
  assign r_hs  = m.rvalid  && m.rready;
  assign aw_hs = m.awvalid && m.awready;
  assign w_hs  = m.wvalid  && m.wready;
  assign b_hs  = m.bvalid  && m.bready;

  assign s0.araddr = m.araddr;
  assign s1.araddr = m.araddr;
  assign s0.awaddr = m.awaddr;
  assign s1.awaddr = m.awaddr;
  assign s0.wdata  = m.wdata;
  assign s1.wdata  = m.wdata;
  assign s0.wmask  = m.wmask;
  assign s1.wmask  = m.wmask;

  always_comb begin : rd_mux
    // NOTE: every output gets a default first, so no path through this block infers a latch.
    m.arready  = 1'b0;
    m.rvalid   = 1'b0;
    m.rdata    = '0;
    m.rresp    = RESP_OKAY;
    s0.arvalid = 1'b0;
    s1.arvalid = 1'b0;
    s0.rready  = 1'b0;
    s1.rready  = 1'b0;
    if (rd_idle) begin
      case (ar_tgt)
        TGT_S0:  begin s0.arvalid = m.arvalid; m.arready = s0.arready; end
        TGT_S1:  begin s1.arvalid = m.arvalid; m.arready = s1.arready; end
        default: m.arready = 1'b1;
      endcase
    end
    if (rd_resp) begin
      case (rd_tgt_q)
        TGT_S0:  begin m.rvalid = s0.rvalid; m.rdata = s0.rdata; m.rresp = s0.rresp; s0.rready = m.rready; end
        TGT_S1:  begin m.rvalid = s1.rvalid; m.rdata = s1.rdata; m.rresp = s1.rresp; s1.rready = m.rready; end
        default: begin m.rvalid = 1'b1; m.rresp = RESP_DECERR; end
      endcase
    end
  end

  always_comb begin : wr_mux
    m.awready  = 1'b0;
    m.wready   = 1'b0;
    m.bvalid   = 1'b0;
    m.bresp    = RESP_OKAY;
    s0.awvalid = 1'b0;
    s1.awvalid = 1'b0;
    s0.wvalid  = 1'b0;
    s1.wvalid  = 1'b0;
    s0.bready  = 1'b0;
    s1.bready  = 1'b0;
    if (wr_idle) begin
      case (aw_tgt)
        TGT_S0:  begin s0.awvalid = m.awvalid; m.awready = s0.awready; end
        TGT_S1:  begin s1.awvalid = m.awvalid; m.awready = s1.awready; end
        default: m.awready = 1'b1;
      endcase
    end
    if (wr_data) begin
      case (wr_tgt_q)
        TGT_S0:  begin s0.wvalid = m.wvalid; m.wready = s0.wready; end
        TGT_S1:  begin s1.wvalid = m.wvalid; m.wready = s1.wready; end
        default: m.wready = 1'b1;
      endcase
    end
    if (wr_resp) begin
      case (wr_tgt_q)
        TGT_S0:  begin m.bvalid = s0.bvalid; m.bresp = s0.bresp; s0.bready = m.bready; end
        TGT_S1:  begin m.bvalid = s1.bvalid; m.bresp = s1.bresp; s1.bready = m.bready; end
        default: begin m.bvalid = 1'b1; m.bresp = RESP_DECERR; end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin : rd_fsm
    if (reset) begin
      rd_state_q <= R_IDLE;
      rd_tgt_q   <= TGT_ERR;
    end else begin
      case (rd_state_q)
        R_IDLE: if (ar_hs) begin
          rd_tgt_q   <= ar_tgt;
          rd_state_q <= R_RESP;
        end
        R_RESP:  if (r_hs) rd_state_q <= R_IDLE;
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin : wr_fsm
    if (reset) begin
      wr_state_q <= W_IDLE;
      wr_tgt_q   <= TGT_ERR;
    end else begin
      case (wr_state_q)
        W_IDLE: if (aw_hs) begin
          wr_tgt_q   <= aw_tgt;
          wr_state_q <= W_DATA;
        end
        W_DATA:  if (w_hs) wr_state_q <= W_RESP;
        W_RESP:  if (b_hs) wr_state_q <= W_IDLE;
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_decoder.sv
// Directed bench for axi_decoder: two reactive slave models, master-side tasks
// with an expected-response scoreboard, and per-slave routing counters.
module tb_axi_decoder;
  import axi_pkg::*;

  localparam int TMO = 50;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_if m_if ();
  axi_if s0_if ();
  axi_if s1_if ();

  axi_decoder dut (
    .clk   (clk),
    .reset (rst),
    .m     (m_if),
    .s0    (s0_if),
    .s1    (s1_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  rd_exp_t    rd_q[$];
  logic [1:0] wr_q[$];

  // Slave model configuration and state
  int          rd_delay [2];
  int          b_delay  [2];
  logic [31:0] rdata_cfg[2];
  logic [1:0]  wready_en;
  logic [1:0]  rd_busy;
  int          rd_cnt [2];
  int          b_cnt  [2];
  logic [1:0]  wr_ph  [2];
  logic [31:0] last_araddr[2], last_awaddr[2], last_wdata[2];
  logic [3:0]  last_wmask [2];
  int          ar_hs[2], aw_hs[2], w_hs[2], touch_rd[2], touch_wr[2];

  logic [1:0]  sl_arready, sl_rvalid, sl_awready, sl_wready, sl_bvalid;
  logic [31:0] sl_rdata[2];
  logic [1:0]  sv_arvalid, sv_rready, sv_awvalid, sv_wvalid, sv_bready;
  logic [31:0] sv_araddr[2], sv_awaddr[2], sv_wdata[2];
  logic [3:0]  sv_wmask[2];

  assign sl_arready = ~rd_busy;
  assign sl_awready = {wr_ph[1] == 2'd0, wr_ph[0] == 2'd0};
  assign sl_wready  = {wr_ph[1] == 2'd1 && wready_en[1], wr_ph[0] == 2'd1 && wready_en[0]};

  assign s0_if.arready = sl_arready[0];
  assign s1_if.arready = sl_arready[1];
  assign s0_if.rvalid  = sl_rvalid[0];
  assign s1_if.rvalid  = sl_rvalid[1];
  assign s0_if.rdata   = sl_rdata[0];
  assign s1_if.rdata   = sl_rdata[1];
  assign s0_if.rresp   = RESP_OKAY;
  assign s1_if.rresp   = RESP_OKAY;
  assign s0_if.awready = sl_awready[0];
  assign s1_if.awready = sl_awready[1];
  assign s0_if.wready  = sl_wready[0];
  assign s1_if.wready  = sl_wready[1];
  assign s0_if.bvalid  = sl_bvalid[0];
  assign s1_if.bvalid  = sl_bvalid[1];
  assign s0_if.bresp   = RESP_OKAY;
  assign s1_if.bresp   = RESP_OKAY;

  assign sv_arvalid = {s1_if.arvalid, s0_if.arvalid};
  assign sv_rready  = {s1_if.rready,  s0_if.rready};
  assign sv_awvalid = {s1_if.awvalid, s0_if.awvalid};
  assign sv_wvalid  = {s1_if.wvalid,  s0_if.wvalid};
  assign sv_bready  = {s1_if.bready,  s0_if.bready};
  assign sv_araddr[0] = s0_if.araddr;
  assign sv_araddr[1] = s1_if.araddr;
  assign sv_awaddr[0] = s0_if.awaddr;
  assign sv_awaddr[1] = s1_if.awaddr;
  assign sv_wdata[0]  = s0_if.wdata;
  assign sv_wdata[1]  = s1_if.wdata;
  assign sv_wmask[0]  = s0_if.wmask;
  assign sv_wmask[1]  = s1_if.wmask;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_busy   <= '0;
      sl_rvalid <= '0;
      sl_bvalid <= '0;
      for (int k = 0; k < 2; k++) begin
        wr_ph[k]    <= 2'd0;
        rd_cnt[k]   <= 0;
        b_cnt[k]    <= 0;
        sl_rdata[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sv_arvalid[k] && sl_arready[k]) begin
          rd_busy[k]     <= 1'b1;
          rd_cnt[k]      <= rd_delay[k];
          last_araddr[k] <= sv_araddr[k];
        end
        if (rd_busy[k] && !sl_rvalid[k]) begin
          if (rd_cnt[k] == 0) begin
            sl_rvalid[k] <= 1'b1;
            sl_rdata[k]  <= rdata_cfg[k];
          end else begin
            rd_cnt[k] <= rd_cnt[k] - 1;
          end
        end
        if (sl_rvalid[k] && sv_rready[k]) begin
          sl_rvalid[k] <= 1'b0;
          rd_busy[k]   <= 1'b0;
        end
        case (wr_ph[k])
          2'd0: if (sv_awvalid[k]) begin
            last_awaddr[k] <= sv_awaddr[k];
            wr_ph[k]       <= 2'd1;
          end
          2'd1: if (sv_wvalid[k] && wready_en[k]) begin
            last_wdata[k] <= sv_wdata[k];
            last_wmask[k] <= sv_wmask[k];
            b_cnt[k]      <= b_delay[k];
            wr_ph[k]      <= 2'd2;
          end
          2'd2: if (b_cnt[k] == 0) begin
            sl_bvalid[k] <= 1'b1;
            wr_ph[k]     <= 2'd3;
          end else begin
            b_cnt[k] <= b_cnt[k] - 1;
          end
          default: if (sv_bready[k]) begin
            sl_bvalid[k] <= 1'b0;
            wr_ph[k]     <= 2'd0;
          end
        endcase
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sv_arvalid[k] && sl_arready[k]) ar_hs[k] <= ar_hs[k] + 1;
      if (sv_awvalid[k] && sl_awready[k]) aw_hs[k] <= aw_hs[k] + 1;
      if (sv_wvalid[k]  && sl_wready[k])  w_hs[k]  <= w_hs[k] + 1;
      if (sv_arvalid[k] || sv_rready[k])  touch_rd[k] <= touch_rd[k] + 1;
      if (sv_awvalid[k] || sv_wvalid[k] || sv_bready[k]) touch_wr[k] <= touch_wr[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_handshake_bits();
    return 32'({m_if.arready, m_if.awready, m_if.wready, m_if.rvalid, m_if.bvalid,
                sv_arvalid, sv_awvalid, sv_wvalid, sv_rready, sv_bready});
  endfunction

  // Caller is positioned 1 time unit after a rising edge; slv 2 means unmapped.
  task automatic do_read(input logic [31:0] addr, input int slv, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int exp_lat, input int hold);
    int n;
    int hs_b[2];
    int tch_b[2];
    rd_exp_t e;
    for (int k = 0; k < 2; k++) begin
      hs_b[k]  = ar_hs[k];
      tch_b[k] = touch_rd[k];
    end
    rd_q.push_back('{data: exp_data, resp: exp_resp});
    m_if.araddr  = addr;
    m_if.arvalid = 1'b1;
    #1;
    n = 0;
    while (m_if.arready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    check("ar_accept", 32'(n < TMO), 32'd1);
    if (slv == 2) check("ar_err_same_cycle", 32'(n), 32'd0);
    @(posedge clk); #1;
    m_if.arvalid = 1'b0;
    n = 0;
    while (m_if.rvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    check("r_latency", 32'(n), 32'(exp_lat));
    e = rd_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("r_held", 32'({m_if.rvalid, m_if.rresp}), 32'({1'b1, e.resp}));
    end
    check("rdata", m_if.rdata, e.data);
    check("rresp", 32'(m_if.rresp), 32'(e.resp));
    m_if.rready = 1'b1;
    @(posedge clk); #1;
    m_if.rready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == slv) begin
        check($sformatf("rd_route_s%0d", k), 32'(ar_hs[k]), 32'(hs_b[k] + 1));
        check($sformatf("rd_addr_s%0d", k), last_araddr[k], addr);
      end else begin
        check($sformatf("rd_untouched_s%0d", k), 32'(touch_rd[k]), 32'(tch_b[k]));
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                          input int slv, input logic [1:0] exp_resp, input int hold, input bit probe);
    int n;
    int aw_b[2];
    int w_b[2];
    int tch_b[2];
    logic [1:0] e;
    for (int k = 0; k < 2; k++) begin
      aw_b[k]  = aw_hs[k];
      w_b[k]   = w_hs[k];
      tch_b[k] = touch_wr[k];
    end
    wr_q.push_back(exp_resp);
    m_if.awaddr  = addr;
    m_if.awvalid = 1'b1;
    m_if.wdata   = data;
    m_if.wmask   = mask;
    m_if.wvalid  = 1'b1;
    #1;
    check("w_blocked_in_aw", 32'(m_if.wready), 32'd0);
    n = 0;
    while (m_if.awready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    check("aw_accept", 32'(n < TMO), 32'd1);
    if (slv == 2) check("aw_err_same_cycle", 32'(n), 32'd0);
    @(posedge clk); #1;
    m_if.awvalid = 1'b0;
    n = 0;
    while (m_if.wready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    if (slv == 2) check("w_err_next_cycle", 32'(n), 32'd0);
    else          check("w_accept", 32'(n < TMO), 32'd1);
    @(posedge clk); #1;
    m_if.wvalid = 1'b0;
    n = 0;
    while (m_if.bvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
    if (slv == 2) check("b_err_next_cycle", 32'(n), 32'd0);
    else          check("b_accept", 32'(n < TMO), 32'd1);
    e = wr_q.pop_front();
    if (probe) begin
      m_if.awaddr  = 32'h8000_0000;
      m_if.awvalid = 1'b1;
      #1;
    end
    for (int i = 0; i < hold; i++) begin
      check("b_held", 32'({m_if.bvalid, m_if.bresp}), 32'({1'b1, e}));
      if (probe) check("aw_blocked", 32'({m_if.awready, s0_if.awvalid}), 32'd0);
      @(posedge clk); #1;
    end
    m_if.awvalid = 1'b0;
    check("bresp", 32'(m_if.bresp), 32'(e));
    m_if.bready = 1'b1;
    @(posedge clk); #1;
    m_if.bready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == slv) begin
        check($sformatf("aw_route_s%0d", k), 32'(aw_hs[k]), 32'(aw_b[k] + 1));
        check($sformatf("w_route_s%0d", k), 32'(w_hs[k]), 32'(w_b[k] + 1));
        check($sformatf("awaddr_s%0d", k), last_awaddr[k], addr);
        check($sformatf("wdata_s%0d", k), last_wdata[k], data);
        check($sformatf("wmask_s%0d", k), 32'(last_wmask[k]), 32'(mask));
      end else begin
        check($sformatf("wr_untouched_s%0d", k), 32'(touch_wr[k]), 32'(tch_b[k]));
      end
    end
  endtask

  initial begin
    int          dr, db;
    logic [31:0] wd;
    rst          = 1'b1;
    m_if.araddr  = '0;
    m_if.arvalid = 1'b0;
    m_if.rready  = 1'b0;
    m_if.awaddr  = '0;
    m_if.awvalid = 1'b0;
    m_if.wdata   = '0;
    m_if.wmask   = '0;
    m_if.wvalid  = 1'b0;
    m_if.bready  = 1'b0;
    rd_delay     = '{0, 0};
    b_delay      = '{0, 0};
    rdata_cfg    = '{32'h0, 32'h0};
    wready_en    = 2'b11;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_low", all_handshake_bits(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_no_resp", 32'({m_if.rvalid, m_if.bvalid, m_if.wready}), 32'd0);
    check("idle_err_arready", 32'(m_if.arready), 32'd1);

    // Memory read with a two-cycle slave response
    rd_delay[0]  = 1;
    rdata_cfg[0] = 32'hDEAD_BEEF;
    do_read(32'h8000_0010, 0, 32'hDEAD_BEEF, RESP_OKAY, 2, 1);

    // Device write, then unmapped read and unmapped write with a stalled B
    do_write(32'hA000_03F8, 32'h0000_0041, 4'b0001, 1, RESP_OKAY, 0, 1'b0);
    do_read(32'h0000_1000, 2, 32'h0, RESP_DECERR, 0, 2);
    do_write(32'h4000_0000, 32'h1234_0000, 4'b1111, 2, RESP_DECERR, 5, 1'b1);

    // Concurrent read of s1 and write to s0 with random response stalls
    for (int i = 0; i < 3; i++) begin
      dr           = int'($urandom_range(0, 4));
      db           = int'($urandom_range(0, 4));
      wd           = $urandom;
      rd_delay[1]  = dr;
      b_delay[0]   = db;
      rdata_cfg[1] = $urandom;
      fork
        do_read(32'hA000_0100 + 32'(i * 4), 1, rdata_cfg[1], RESP_OKAY, dr + 1, 0);
        do_write(32'h8000_0200 + 32'(i * 4), wd, 4'(4'hF ^ i), 0, RESP_OKAY, 0, 1'b0);
      join
    end

    // Reset with the read stuck in R_RESP and the write stuck in W_DATA
    rd_delay[0]  = 30;
    wready_en[1] = 1'b0;
    m_if.araddr  = 32'h8000_0040;
    m_if.arvalid = 1'b1;
    m_if.awaddr  = 32'hA000_0000;
    m_if.awvalid = 1'b1;
    m_if.wdata   = 32'hCAFE_F00D;
    m_if.wmask   = 4'hF;
    m_if.wvalid  = 1'b1;
    #1;
    check("pre_reset_both_accept", 32'({m_if.arready, m_if.awready}), 32'b11);
    @(posedge clk); #1;
    m_if.rready = 1'b1;
    m_if.bready = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_stuck", 32'({s1_if.wvalid, s0_if.rready, m_if.rvalid}), 32'b110);
    rst = 1'b1;
    #1;
    check("mid_txn_reset_low", all_handshake_bits(), 32'd0);
    m_if.arvalid = 1'b0;
    m_if.awvalid = 1'b0;
    m_if.wvalid  = 1'b0;
    m_if.rready  = 1'b0;
    m_if.bready  = 1'b0;
    rd_delay[0]  = 0;
    wready_en    = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", 32'({m_if.rvalid, m_if.bvalid, m_if.wready}), 32'd0);
    rdata_cfg[0] = 32'h1234_5678;
    do_read(32'h8000_0080, 0, 32'h1234_5678, RESP_OKAY, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
